// File: rtl/sram_sp_pipe.sv
`default_nettype none
// ============================================================================
// Module  : sram_sp_pipe
// Brief   : Single-port SRAM with byte strobes, pipelined reads, ready handshake,
//           optional post-reset clear sweep and out-of-range read flagging.
// Revision: 1.0 - initial release
// ============================================================================
module sram_sp_pipe #(
    parameter int DATASIZE       = 32,
    parameter int ADDRSIZE       = 10,
    parameter int DEPTH          = 1024,
    parameter int RD_LAT         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  CEN,
    input  logic                  WEN,
    input  logic [ADDRSIZE-1:0]   ADDR,
    input  logic [DATASIZE-1:0]   WDATA,
    input  logic [DATASIZE/8-1:0] WSTRB,
    output logic                  ready,
    output logic [DATASIZE-1:0]   RDATA,
    output logic                  out_valid,
    output logic                  rerr,
    output logic                  init_done
);

    localparam int                c_nb    = DATASIZE / 8;
    localparam logic [ADDRSIZE:0] c_depth = (ADDRSIZE+1)'(DEPTH);
    localparam logic [ADDRSIZE-1:0] c_last = ADDRSIZE'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    logic [ADDRSIZE-1:0]   r_clr_cnt;
    logic                  r_ready;
    logic                  r_init_done;
    logic [DATASIZE-1:0]   r_mem [DEPTH];

    logic                  r_pv [RD_LAT];
    logic                  r_pe [RD_LAT];
    logic [DATASIZE-1:0]   r_pd [RD_LAT];

    logic                  w_in_range;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_sweep;
    logic                  w_we;
    logic [ADDRSIZE-1:0]   w_waddr;
    logic [DATASIZE-1:0]   w_wdata;
    logic [c_nb-1:0]       w_wstrb;

    // Range check uses the full address so nothing aliases back into the array.
    assign w_in_range = ({1'b0, ADDR} < c_depth);
    assign w_rd       = r_ready & ~CEN & WEN;
    assign w_wr       = r_ready & ~CEN & ~WEN & w_in_range;
    assign w_sweep    = (r_state == ST_INIT) && (CLEAR_ON_RESET != 0);

    always_comb begin
        w_we    = w_sweep | w_wr;
        w_waddr = ADDR;
        w_wdata = WDATA;
        w_wstrb = WSTRB;
        if (w_sweep) begin
            w_waddr = r_clr_cnt;
            w_wdata = '0;
            w_wstrb = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_INIT;
            r_clr_cnt   <= '0;
            r_ready     <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if ((CLEAR_ON_RESET == 0) || (r_clr_cnt == c_last)) begin
                        r_state     <= ST_RUN;
                        r_ready     <= 1'b1;
                        r_init_done <= 1'b1;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    // Storage is deliberately left out of the reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (!rst && w_we) begin
            for (int i = 0; i < c_nb; i++) begin
                if (w_wstrb[i]) begin
                    r_mem[w_waddr][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_pv[i] <= 1'b0;
                r_pe[i] <= 1'b0;
                r_pd[i] <= '0;
            end
        end else begin
            r_pv[0] <= w_rd;
            r_pe[0] <= w_rd & ~w_in_range;
            r_pd[0] <= (w_rd && w_in_range) ? r_mem[ADDR] : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pe[i] <= r_pe[i-1];
                r_pd[i] <= r_pd[i-1];
            end
        end
    end

    assign ready     = r_ready;
    assign init_done = r_init_done;
    assign out_valid = r_pv[RD_LAT-1];
    assign rerr      = r_pe[RD_LAT-1];
    assign RDATA     = r_pd[RD_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_sram_sp_pipe.sv
`default_nettype none
// Bench for sram_sp_pipe: three configurations share one command bus and are
// checked every cycle against a cycle-scheduled behavioural memory model.
module tb_sram_sp_pipe;

    localparam int NI  = 3;
    localparam int DEP = 20;

    logic        clk;
    logic        rst;
    logic        cen;
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    logic        rdy  [NI];
    logic [31:0] rdat [NI];
    logic        ov   [NI];
    logic        re   [NI];
    logic        idn  [NI];

    int lat_tab [NI] = '{1, 3, 2};
    int clr_tab [NI] = '{1, 1, 0};

    sram_sp_pipe #(.DATASIZE(32), .ADDRSIZE(5), .DEPTH(DEP), .RD_LAT(1), .CLEAR_ON_RESET(1)) u_d0 (
        .clk(clk), .rst(rst), .CEN(cen), .WEN(wen), .ADDR(addr), .WDATA(wdata), .WSTRB(wstrb),
        .ready(rdy[0]), .RDATA(rdat[0]), .out_valid(ov[0]), .rerr(re[0]), .init_done(idn[0]));
    sram_sp_pipe #(.DATASIZE(32), .ADDRSIZE(5), .DEPTH(DEP), .RD_LAT(3), .CLEAR_ON_RESET(1)) u_d1 (
        .clk(clk), .rst(rst), .CEN(cen), .WEN(wen), .ADDR(addr), .WDATA(wdata), .WSTRB(wstrb),
        .ready(rdy[1]), .RDATA(rdat[1]), .out_valid(ov[1]), .rerr(re[1]), .init_done(idn[1]));
    sram_sp_pipe #(.DATASIZE(32), .ADDRSIZE(5), .DEPTH(DEP), .RD_LAT(2), .CLEAR_ON_RESET(0)) u_d2 (
        .clk(clk), .rst(rst), .CEN(cen), .WEN(wen), .ADDR(addr), .WDATA(wdata), .WSTRB(wstrb),
        .ready(rdy[2]), .RDATA(rdat[2]), .out_valid(ov[2]), .rerr(re[2]), .init_done(idn[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mm [NI][DEP];
    logic [3:0]  mk [NI][DEP];          // which bytes hold a known value
    logic        active [NI];
    logic        m_rdy [NI];
    logic        m_done [NI];
    int          left [NI];              // INIT cycles still to run
    // Expected results scheduled by the cycle they must appear in.
    logic        sv [NI][4];
    logic [31:0] sd [NI][4];
    logic [31:0] sm [NI][4];
    logic        se [NI][4];
    int          cyc = 0;
    int          vcount [NI];
    logic [31:0] last_d [NI];
    logic        last_e [NI];

    initial begin
        for (int k = 0; k < NI; k++) begin
            active[k] = 1'b0; m_rdy[k] = 1'b0; m_done[k] = 1'b0; left[k] = 0;
            vcount[k] = 0; last_d[k] = '0; last_e[k] = 1'b0;
            for (int a = 0; a < DEP; a++) begin mm[k][a] = '0; mk[k][a] = '0; end
            for (int s = 0; s < 4; s++) begin sv[k][s] = 1'b0; sd[k][s] = '0; sm[k][s] = '0; se[k][s] = 1'b0; end
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                int slot;
                logic        ev;
                logic [31:0] ed, em;
                logic        ee;
                slot = cyc % 4;
                ev = sv[k][slot];
                ed = ev ? sd[k][slot] : 32'h0;
                em = ev ? sm[k][slot] : 32'hFFFF_FFFF;
                ee = ev ? se[k][slot] : 1'b0;
                if (active[k]) begin
                    check($sformatf("ready[%0d]", k), {31'b0, rdy[k]}, {31'b0, m_rdy[k]});
                    check($sformatf("init_done[%0d]", k), {31'b0, idn[k]}, {31'b0, m_done[k]});
                    check($sformatf("out_valid[%0d]", k), {31'b0, ov[k]}, {31'b0, ev});
                    check($sformatf("rerr[%0d]", k), {31'b0, re[k]}, {31'b0, ee});
                    check($sformatf("rdata[%0d]", k), rdat[k] & em, ed & em);
                end
                if (ov[k]) begin
                    vcount[k]++;
                    last_d[k] = rdat[k];
                    last_e[k] = re[k];
                end
                sv[k][slot] = 1'b0;
                // Advance the model across the coming rising edge.
                if (rst) begin
                    active[k] = 1'b1;
                    left[k]   = (clr_tab[k] != 0) ? DEP : 1;
                    m_rdy[k]  = 1'b0;
                    m_done[k] = 1'b0;
                    for (int s = 0; s < 4; s++) sv[k][s] = 1'b0;
                end else if (active[k]) begin
                    if (m_rdy[k]) begin
                        if (!cen && wen) begin
                            int ds;
                            ds = (cyc + lat_tab[k]) % 4;
                            sv[k][ds] = 1'b1;
                            if (int'(addr) < DEP) begin
                                logic [31:0] msk;
                                for (int b = 0; b < 4; b++) msk[8*b +: 8] = mk[k][addr][b] ? 8'hFF : 8'h00;
                                sd[k][ds] = mm[k][addr] & msk;
                                sm[k][ds] = msk;
                                se[k][ds] = 1'b0;
                            end else begin
                                sd[k][ds] = '0;
                                sm[k][ds] = 32'hFFFF_FFFF;
                                se[k][ds] = 1'b1;
                            end
                        end else if (!cen && int'(addr) < DEP) begin
                            for (int b = 0; b < 4; b++) begin
                                if (wstrb[b]) begin
                                    mm[k][addr][8*b +: 8] = wdata[8*b +: 8];
                                    mk[k][addr][b] = 1'b1;
                                end
                            end
                        end
                    end else begin
                        if (clr_tab[k] != 0) begin
                            mm[k][DEP-left[k]] = '0;
                            mk[k][DEP-left[k]] = 4'hF;
                        end
                        left[k]--;
                        if (left[k] == 0) begin
                            m_rdy[k]  = 1'b1;
                            m_done[k] = 1'b1;
                        end
                    end
                end
            end
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        cen = 1'b0; wen = 1'b0; addr = a; wdata = d; wstrb = s;
        step();
        cen = 1'b1; wen = 1'b1;
    endtask

    task automatic rd(input logic [4:0] a);
        cen = 1'b0; wen = 1'b1; addr = a;
        step();
        cen = 1'b1;
    endtask

    // Drop rst and count edges until each instance raises ready.
    task automatic release_and_time(input string tag);
        int n0, n1, n2, n;
        n0 = -1; n1 = -1; n2 = -1; n = 0;
        rst = 1'b0;
        while ((n0 < 0 || n1 < 0 || n2 < 0) && n < 60) begin
            step();
            n++;
            if (rdy[0] && n0 < 0) n0 = n;
            if (rdy[1] && n1 < 0) n1 = n;
            if (rdy[2] && n2 < 0) n2 = n;
        end
        check({tag, " ready_delay[0]"}, n0, 20);
        check({tag, " ready_delay[1]"}, n1, 20);
        check({tag, " ready_delay[2]"}, n2, 1);
    endtask

    task automatic rd_expect(input string tag, input logic [4:0] a,
                             input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                             input logic ee);
        int vc [NI];
        logic [31:0] ex [NI];
        ex[0] = e0; ex[1] = e1; ex[2] = e2;
        for (int k = 0; k < NI; k++) vc[k] = vcount[k];
        rd(a);
        repeat (4) step();
        for (int k = 0; k < NI; k++) begin
            check($sformatf("%s nvalid[%0d]", tag, k), vcount[k], vc[k] + 1);
            check($sformatf("%s data[%0d]", tag, k), last_d[k], ex[k]);
            check($sformatf("%s err[%0d]", tag, k), {31'b0, last_e[k]}, {31'b0, ee});
        end
    endtask

    initial begin
        rst = 1'b1; cen = 1'b1; wen = 1'b1; addr = '0; wdata = '0; wstrb = '0;
        repeat (2) step();
        release_and_time("por");

        // Clear sweep wipes old contents only where the sweep is enabled.
        wr(5'd7, 32'hDEADBEEF, 4'hF);
        wr(5'd4, 32'h0000_0009, 4'hF);
        rst = 1'b1;
        step();
        release_and_time("sweep");
        rd_expect("clr7", 5'd7, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0);
        rd_expect("keep4", 5'd4, 32'h0, 32'h0, 32'h9, 1'b0);

        // Byte strobes.
        wr(5'd3, 32'h11223344, 4'hF);
        wr(5'd3, 32'hAABBCCDD, 4'b0101);
        rd_expect("strb", 5'd3, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 1'b0);

        // Pipelined back-to-back reads.
        for (int i = 0; i < 4; i++) wr(5'(i), 32'(i), 4'hF);
        begin
            int vc1;
            vc1 = vcount[1];
            for (int i = 0; i < 4; i++) rd(5'(i));
            repeat (5) step();
            check("pipe nvalid[1]", vcount[1], vc1 + 4);
            check("pipe last[1]", last_d[1], 32'h3);
        end

        // Out-of-range access.
        wr(5'd25, 32'h5, 4'hF);
        rd_expect("oor25", 5'd25, 32'h0, 32'h0, 32'h0, 1'b1);
        wr(5'd19, 32'h77, 4'hF);
        rd_expect("in19", 5'd19, 32'h77, 32'h77, 32'h77, 1'b0);

        // Reset with reads in flight: the 3-deep pipe must never emit them.
        begin
            int vc1;
            vc1 = vcount[1];
            rd(5'd1);
            rd(5'd2);
            rst = 1'b1;
            step();
            release_and_time("midrst");
            check("midrst nvalid[1]", vcount[1], vc1);
        end

        // Randomised traffic with occasional resets.
        for (int it = 0; it < 600; it++) begin
            rst   = ($urandom_range(0, 249) == 0);
            cen   = ($urandom_range(0, 3) == 0);
            wen   = $urandom_range(0, 1) != 0;
            addr  = 5'($urandom_range(0, 31));
            wdata = $urandom;
            wstrb = 4'($urandom_range(0, 15));
            step();
        end
        rst = 1'b0; cen = 1'b1; wen = 1'b1;
        repeat (30) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
